axis_pcm_rx: RTL and testbench

Post-domain packet sink for the audio path: consumes the byte-wide AXIS packet stream (tuser = packet length in bytes) delivered by the dual-clock packet buffer. It packs bytes into 16-bit little-endian PCM samples, buffers them in an internal sample FIFO, and releases one sample per `i_sample_tick`. Framing errors, underrun and overflow are reported as single-cycle pulses.

---
 rtl/axis_pcm_rx.sv | 216 +++++++++++++++++++++
 tb/tb_axis_pcm_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pcm_rx.sv
// axis_pcm_rx: byte-wide AXIS packet sink that packs little-endian 16-bit PCM samples into a FIFO
// and releases one per i_sample_tick. Build macro AXIS_PCM_RX_LEN_CHECK_EN enables length checking.

module axis_pcm_rx #(
  parameter int P_FIFO_DEPTH = 512,
  parameter int P_MAX_LEN    = 1024
) (
  input  logic                          i_post_clk,
  input  logic                          i_post_rst,
  input  logic [7:0]                    i_axis_data,
  input  logic [15:0]                   i_axis_user,
  input  logic                          i_axis_valid,
  input  logic                          i_axis_last,
  output logic                          o_axis_ready,
  input  logic                          i_sample_tick,
  output logic [15:0]                   o_pcm_data,
  output logic                          o_pcm_valid,
  output logic                          o_underrun,
  output logic                          o_overflow,
  output logic                          o_len_err,
  output logic [15:0]                   o_pkt_cnt,
  output logic [$clog2(P_FIFO_DEPTH):0] o_fifo_level
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [7:0]    held_q;
  logic          held_vld_q;
  logic [15:0]   pkt_cnt_q;
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
  logic [15:0]   len_q;
  logic          len_err_q;
`else
  logic          unused_user;
`endif

  logic [15:0]   mem [P_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [15:0]   pcm_data_q;
  logic          pcm_valid_q;
  logic          underrun_q;
  logic          overflow_q;

  logic [31:0]   free_slots;
  logic          ready;
  logic          beat;
  logic          pack_beat;
  logic          odd_byte;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          do_write;
  logic          do_pop;

  // Handshake: a beat transfers when i_axis_valid && o_axis_ready in the same cycle. Ready is only
  // withheld in IDLE (admission threshold); mid-packet it stays high because upstream ignores it.
  assign free_slots   = 32'(P_FIFO_DEPTH) - 32'(level_q);
  assign ready        = (state_q != ST_IDLE) || (free_slots >= 32'(P_MAX_LEN / 2));
  assign o_axis_ready = ready;
  assign beat         = i_axis_valid && ready;
  assign pack_beat    = beat && (state_q != ST_SKIP);
  assign odd_byte     = (state_q == ST_RECV) && cnt_q[0];

  assign full     = (level_q == LW'(P_FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign do_write = wr_en && !full;
  assign do_pop   = i_sample_tick && !empty;

  // An odd byte completes a sample; a last on an even byte, or a pending low byte when a skipped
  // packet finally ends, is flushed with a zero high byte.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (pack_beat && odd_byte) begin
      wr_en   = 1'b1;
      wr_data = {i_axis_data, held_q};
    end else if (pack_beat && i_axis_last) begin
      wr_en   = 1'b1;
      wr_data = {8'h00, i_axis_data};
    end else if (beat && (state_q == ST_SKIP) && i_axis_last && held_vld_q) begin
      wr_en   = 1'b1;
      wr_data = {8'h00, held_q};
    end
  end

  always_ff @(posedge i_post_clk or posedge i_post_rst) begin
    if (i_post_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      pkt_cnt_q  <= '0;
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
      len_q      <= '0;
      len_err_q  <= 1'b0;
`endif
    end else begin
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
      len_err_q <= 1'b0;
`endif
      if (beat) begin
        if (pack_beat && !odd_byte) begin
          held_q     <= i_axis_data;
          held_vld_q <= 1'b1;
        end else if (pack_beat) begin
          held_vld_q <= 1'b0;
        end
        case (state_q)
          ST_IDLE: begin
            cnt_q <= 16'd1;
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
            len_q <= i_axis_user;
            if (i_axis_last) begin
              len_err_q <= (i_axis_user != 16'd1);
            end else if (i_axis_user == 16'd1) begin
              state_q <= ST_SKIP;
            end else begin
              state_q <= ST_RECV;
            end
`else
            if (!i_axis_last) begin
              state_q <= ST_RECV;
            end
`endif
          end
          ST_RECV: begin
            cnt_q <= cnt_q + 16'd1;
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
            if (i_axis_last) begin
              len_err_q <= ((cnt_q + 16'd1) != len_q) || (len_q == 16'd0);
            end else if ((cnt_q + 16'd1) == len_q) begin
              state_q <= ST_SKIP;
            end
`endif
          end
          default: begin
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
            if (i_axis_last) begin
              len_err_q <= 1'b1;
            end
`endif
          end
        endcase
        if (i_axis_last) begin
          state_q    <= ST_IDLE;
          held_vld_q <= 1'b0;
          pkt_cnt_q  <= pkt_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_post_clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Emptiness and fullness are judged on the level before this cycle's write/pop.
  always_ff @(posedge i_post_clk or posedge i_post_rst) begin
    if (i_post_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pcm_valid_q <= do_pop;
      underrun_q  <= i_sample_tick && empty;
      overflow_q  <= wr_en && full;
      if (do_pop) begin
        pcm_data_q <= mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end else if (i_sample_tick) begin
        pcm_data_q <= '0;
      end
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      case ({do_write, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef AXIS_PCM_RX_LEN_CHECK_EN
  assign o_len_err = len_err_q;
`else
  assign o_len_err   = 1'b0;
  assign unused_user = ^i_axis_user;
`endif

  assign o_pcm_data   = pcm_data_q;
  assign o_pcm_valid  = pcm_valid_q;
  assign o_underrun   = underrun_q;
  assign o_overflow   = overflow_q;
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_axis_pcm_rx.sv
// Self-checking bench for axis_pcm_rx: scoreboard of expected PCM samples plus per-scenario checks.
// Honours AXIS_PCM_RX_LEN_CHECK_EN so the same bench covers both builds.

module tb_axis_pcm_rx;

  localparam int DEPTH = 512;
  localparam int LW    = 10;
`ifdef AXIS_PCM_RX_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [7:0]    i_axis_data;
  logic [15:0]   i_axis_user;
  logic          i_axis_valid;
  logic          i_axis_last;
  logic          o_axis_ready;
  logic          i_sample_tick;
  logic [15:0]   o_pcm_data;
  logic          o_pcm_valid;
  logic          o_underrun;
  logic          o_overflow;
  logic          o_len_err;
  logic [15:0]   o_pkt_cnt;
  logic [LW-1:0] o_fifo_level;

  logic [15:0] exp_q[$];
  logic [7:0]  pkt_b[$];
  logic [15:0] sb_exp;
  int n_checks, n_fail;
  int exp_len_err, seen_len_err, exp_ovf, seen_ovf, exp_und, seen_und, exp_pkt;

  axis_pcm_rx #(.P_FIFO_DEPTH(DEPTH), .P_MAX_LEN(1024)) dut (
    .i_post_clk   (clk),
    .i_post_rst   (rst),
    .i_axis_data  (i_axis_data),
    .i_axis_user  (i_axis_user),
    .i_axis_valid (i_axis_valid),
    .i_axis_last  (i_axis_last),
    .o_axis_ready (o_axis_ready),
    .i_sample_tick(i_sample_tick),
    .o_pcm_data   (o_pcm_data),
    .o_pcm_valid  (o_pcm_valid),
    .o_underrun   (o_underrun),
    .o_overflow   (o_overflow),
    .o_len_err    (o_len_err),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_fifo_level (o_fifo_level)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (o_len_err)  seen_len_err++;
      if (o_overflow) seen_ovf++;
      if (o_underrun) seen_und++;
      if (o_pcm_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h, required no sample", o_pcm_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (o_pcm_data !== sb_exp) begin
            n_fail++;
            $display("FAIL sb_data: got %h, required %h", o_pcm_data, sb_exp);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sample(input logic [15:0] s);
    if (exp_q.size() < DEPTH) exp_q.push_back(s);
    else exp_ovf++;
  endtask

  // Driver: sends pkt_b as one packet; tick_mask[i] raises the tick alongside beat i.
  task automatic send_pkt(input logic [15:0] user, input logic close, input logic [31:0] tick_mask);
    int n;
    int kept;
    int waitc;
    n     = pkt_b.size();
    kept  = (LEN_CHK && user != 16'd0 && n > int'(user)) ? int'(user) : n;
    waitc = 0;
    while (!o_axis_ready && waitc < 2000) begin
      step(1);
      waitc++;
    end
    if (!o_axis_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready %b after %0d cycles, required 1", o_axis_ready, waitc);
    end
    for (int i = 0; i < n; i++) begin
      i_axis_data   = pkt_b[i];
      i_axis_user   = user;
      i_axis_valid  = 1'b1;
      i_axis_last   = close && (i == n - 1);
      i_sample_tick = (i < 32) ? tick_mask[i] : 1'b0;
      if (i < kept && (i % 2) == 1) push_sample({pkt_b[i], pkt_b[i-1]});
      if (close && i == n - 1 && (kept % 2) == 1) push_sample({8'h00, pkt_b[kept-1]});
      step(1);
    end
    i_axis_valid  = 1'b0;
    i_axis_last   = 1'b0;
    i_sample_tick = 1'b0;
    if (close) begin
      exp_pkt++;
      if (LEN_CHK && (n != int'(user) || user == 16'd0)) exp_len_err++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (o_fifo_level != '0 && k < 2000) begin
      i_sample_tick = 1'b1;
      step(1);
      k++;
    end
    i_sample_tick = 1'b0;
    step(1);
    n_checks++;
    if (o_fifo_level !== '0) begin
      n_fail++;
      $display("FAIL drain_level: got %0d, required 0", o_fifo_level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_axis_data = '0; i_axis_user = '0; i_axis_valid = 1'b0; i_axis_last = 1'b0; i_sample_tick = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    n_checks++;
    if ({o_axis_ready, o_pcm_data, o_pcm_valid, o_underrun, o_overflow, o_len_err, o_pkt_cnt, o_fifo_level}
        !== {1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b pcm=%h v=%b u=%b o=%b le=%b cnt=%0d lvl=%0d, required 1/0/0/0/0/0/0/0",
               o_axis_ready, o_pcm_data, o_pcm_valid, o_underrun, o_overflow, o_len_err, o_pkt_cnt, o_fifo_level);
    end
  endtask

  task automatic test_four_byte();
    pkt_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(16'd4, 1'b1, 32'h0);
    n_checks++;
    if (o_fifo_level !== 10'd2) begin
      n_fail++; $display("FAIL four_level: got %0d, required 2", o_fifo_level);
    end
    step(1);
    n_checks++;
    if (o_pkt_cnt !== 16'(exp_pkt)) begin
      n_fail++; $display("FAIL four_pkt_cnt: got %0d, required %0d", o_pkt_cnt, exp_pkt);
    end
    i_sample_tick = 1'b1;
    step(1);
    i_sample_tick = 1'b0;
    n_checks++;
    if (o_pcm_valid !== 1'b1 || o_fifo_level !== 10'd1) begin
      n_fail++; $display("FAIL four_tick: valid %b level %0d, required 1 and 1", o_pcm_valid, o_fifo_level);
    end
    drain();
  endtask

  task automatic test_odd_len();
    pkt_b = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(16'd3, 1'b1, 32'h0);
    step(1);
    n_checks++;
    if (o_fifo_level !== 10'd2 || seen_len_err != exp_len_err) begin
      n_fail++; $display("FAIL odd_len: level %0d len_err %0d, required 2 and %0d", o_fifo_level, seen_len_err, exp_len_err);
    end
    drain();
  endtask

  task automatic test_short_pkt();
    pkt_b = '{8'h11, 8'h22};
    send_pkt(16'd4, 1'b1, 32'h0);
    step(1);
    n_checks++;
    if (seen_len_err != exp_len_err || o_fifo_level !== 10'd1) begin
      n_fail++; $display("FAIL short_pkt: len_err %0d level %0d, required %0d and 1", seen_len_err, o_fifo_level, exp_len_err);
    end
    drain();
  endtask

  task automatic test_skip();
    pkt_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(16'd2, 1'b1, 32'h0);
    step(1);
    n_checks++;
    if (o_fifo_level !== (LEN_CHK ? 10'd1 : 10'd2) || seen_len_err != exp_len_err) begin
      n_fail++; $display("FAIL skip: level %0d len_err %0d, required %0d and %0d",
                         o_fifo_level, seen_len_err, LEN_CHK ? 1 : 2, exp_len_err);
    end
    drain();
  endtask

  task automatic test_underrun();
    i_sample_tick = 1'b1;
    exp_und++;
    step(1);
    i_sample_tick = 1'b0;
    n_checks++;
    if (o_pcm_data !== 16'h0 || o_underrun !== 1'b1 || o_pcm_valid !== 1'b0) begin
      n_fail++; $display("FAIL underrun: data %h und %b valid %b, required 0000 1 0", o_pcm_data, o_underrun, o_pcm_valid);
    end
    step(1);
    n_checks++;
    if (o_underrun !== 1'b0) begin
      n_fail++; $display("FAIL underrun_pulse: got %b, required 0", o_underrun);
    end
  endtask

  task automatic test_tick_write();
    pkt_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_und++;
    send_pkt(16'd6, 1'b1, 32'b1010);
    step(1);
    n_checks++;
    if (o_fifo_level !== 10'd2 || seen_und != exp_und) begin
      n_fail++; $display("FAIL tick_write: level %0d underruns %0d, required 2 and %0d", o_fifo_level, seen_und, exp_und);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    pkt_b = '{8'h7A, 8'h7B};
    send_pkt(16'd2, 1'b1, 32'h0);
    n_checks++;
    if (o_axis_ready !== 1'b0) begin
      n_fail++; $display("FAIL threshold_block: ready %b, required 0", o_axis_ready);
    end
    i_sample_tick = 1'b1;
    step(1);
    i_sample_tick = 1'b0;
    n_checks++;
    if (o_axis_ready !== 1'b1) begin
      n_fail++; $display("FAIL threshold_open: ready %b, required 1", o_axis_ready);
    end
    pkt_b = '{8'h7C, 8'h7D};
    send_pkt(16'd2, 1'b1, 32'h0);
    n_checks++;
    if (o_fifo_level !== 10'd1) begin
      n_fail++; $display("FAIL back_to_back_level: got %0d, required 1", o_fifo_level);
    end
    drain();
  endtask

  task automatic test_overflow();
    pkt_b.delete();
    for (int i = 0; i < 1026; i++) pkt_b.push_back(8'($urandom_range(0, 255)));
    send_pkt(16'd1026, 1'b1, 32'h0);
    step(1);
    n_checks++;
    if (o_fifo_level !== 10'd512 || seen_ovf != exp_ovf || exp_ovf != 1) begin
      n_fail++; $display("FAIL overflow: level %0d overflows %0d, required 512 and 1", o_fifo_level, seen_ovf);
    end
    n_checks++;
    if (o_axis_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b, required 0", o_axis_ready);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    pkt_b = '{8'h31, 8'h32, 8'h33};
    send_pkt(16'd8, 1'b0, 32'h0);
    rst = 1'b1;
    exp_q.delete();
    exp_pkt = 0;
    step(1);
    n_checks++;
    if ({o_axis_ready, o_pcm_data, o_pcm_valid, o_underrun, o_overflow, o_len_err, o_pkt_cnt, o_fifo_level}
        !== {1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 10'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_values: rdy=%b pcm=%h v=%b u=%b o=%b le=%b cnt=%0d lvl=%0d, required 1/0/0/0/0/0/0/0",
               o_axis_ready, o_pcm_data, o_pcm_valid, o_underrun, o_overflow, o_len_err, o_pkt_cnt, o_fifo_level);
    end
    rst = 1'b0;
    step(1);
    pkt_b = '{8'h5A};
    send_pkt(16'd8, 1'b1, 32'h0);
    step(1);
    n_checks++;
    if (o_pkt_cnt !== 16'd1 || o_fifo_level !== 10'd1 || seen_len_err != exp_len_err) begin
      n_fail++; $display("FAIL trailing_pkt: cnt %0d level %0d len_err %0d, required 1 1 %0d",
                         o_pkt_cnt, o_fifo_level, seen_len_err, exp_len_err);
    end
    drain();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    exp_len_err = 0; seen_len_err = 0; exp_ovf = 0; seen_ovf = 0;
    exp_und = 0; seen_und = 0; exp_pkt = 0;
    test_reset();
    test_four_byte();
    test_odd_len();
    test_short_pkt();
    test_skip();
    test_underrun();
    test_tick_write();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    step(2);
    n_checks++;
    if (exp_q.size() != 0 || seen_und != exp_und) begin
      n_fail++; $display("FAIL final_state: %0d samples pending, underruns %0d, required 0 and %0d",
                         exp_q.size(), seen_und, exp_und);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
